// File: rtl/mdu_pkg.sv
// Shared definitions for the RV64M multi-cycle multiply/divide sequencer.
//   XLEN      operand/result width
//   CNT_W     width of the iteration counter (must hold XLEN)
//   OP_*      bit positions of the one-hot in_op encoding
//   state_t   sequencer states
//   DIV0_QUO  quotient returned for division by zero
//   INT_MIN   most negative XLEN-bit value (signed-division overflow dividend)
package mdu_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = 7;

    localparam int OP_MUL    = 0;
    localparam int OP_MULH   = 1;
    localparam int OP_MULHU  = 2;
    localparam int OP_MULHSU = 3;
    localparam int OP_DIV    = 4;
    localparam int OP_DIVU   = 5;
    localparam int OP_REM    = 6;
    localparam int OP_REMU   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] DIV0_QUO = '1;
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/mdu_seq_if.sv
// Request/response bundle between the EXU and the multiply/divide sequencer.
//   in_valid/in_ready    request handshake
//   in_op                one-hot {remu,rem,divu,div,mulhsu,mulhu,mulh,mul}
//   in_src1/in_src2      rs1/rs2 values
//   out_valid/out_ready  result handshake
//   out_result           result, stable while out_valid && !out_ready
//   busy                 sequencer not idle
// master: EXU side.  slave: sequencer side.
interface mdu_seq_if;

    logic                      in_valid;
    logic                      in_ready;
    logic [7:0]                in_op;
    logic [mdu_pkg::XLEN-1:0]  in_src1;
    logic [mdu_pkg::XLEN-1:0]  in_src2;
    logic                      out_valid;
    logic                      out_ready;
    logic [mdu_pkg::XLEN-1:0]  out_result;
    logic                      busy;

    modport master (
        output in_valid, in_op, in_src1, in_src2, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, out_ready,
        output in_ready, out_valid, out_result, busy
    );

endinterface

// File: rtl/mdu_addsub.sv
// W-bit adder/subtractor with carry-out, shared by the multiply and divide steps.
//   a, b   operands
//   sub    1: a - b (cout=1 means no borrow, i.e. a >= b); 0: a + b
//   sum    W-bit result
//   cout   carry out of the top bit
module mdu_addsub #(
    parameter int W = 65
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    // Subtraction as a + ~b + 1 so the carry-out doubles as the "no borrow" flag.
    assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{W{1'b0}}, sub};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV64M multiply/divide sequencer. One bit per cycle on a shared
// XLEN+1-bit adder: shift-add multiply, restoring divide, then one sign-fix cycle.
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   flush     synchronous kill of any in-flight op, highest priority
//   bus       mdu_seq_if slave: request/response handshakes, result, busy
module mdu_seq
    import mdu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    mdu_seq_if.slave    bus
);

    state_t            state, state_next;
    logic [7:0]        op_q;
    logic              sign1_q, sign2_q;
    logic [XLEN-1:0]   opnd_q;      // multiplicand (mul) or divisor (div), magnitude
    logic [XLEN-1:0]   acc_q;       // product high half / partial remainder
    logic [XLEN-1:0]   lsr_q;       // product low half / dividend shifting into quotient
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    // ---------------- request decode ----------------
    logic [7:0]        op;
    logic              op_valid, is_mul, s1_signed, s2_signed;
    logic              neg1, neg2, src2_zero, div_ovf, accept;
    logic [XLEN-1:0]   abs1, abs2;

    assign op        = bus.in_op;
    assign op_valid  = (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
    assign is_mul    = |op[OP_MULHSU:OP_MUL];
    assign s1_signed = op[OP_MUL] | op[OP_MULH] | op[OP_MULHSU] | op[OP_DIV] | op[OP_REM];
    assign s2_signed = op[OP_MUL] | op[OP_MULH] | op[OP_DIV] | op[OP_REM];
    assign neg1      = s1_signed & bus.in_src1[XLEN-1];
    assign neg2      = s2_signed & bus.in_src2[XLEN-1];
    assign abs1      = neg1 ? (~bus.in_src1 + 1'b1) : bus.in_src1;
    assign abs2      = neg2 ? (~bus.in_src2 + 1'b1) : bus.in_src2;
    assign src2_zero = (bus.in_src2 == '0);
    assign div_ovf   = (bus.in_src1 == INT_MIN) && (bus.in_src2 == '1);
    assign accept    = (state == IDLE) && bus.in_valid && !flush;

    // Ops whose result is known at accept time skip the iteration entirely.
    logic            special;
    logic [XLEN-1:0] special_res;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        special     = 1'b1;
        special_res = '0;
        if (!op_valid) begin
            special_res = '0;
        end else if ((op[OP_DIV] | op[OP_DIVU]) && src2_zero) begin
            special_res = DIV0_QUO;
        end else if ((op[OP_REM] | op[OP_REMU]) && src2_zero) begin
            special_res = bus.in_src1;
        end else if (op[OP_DIV] && div_ovf) begin
            special_res = bus.in_src1;
        end else if (op[OP_REM] && div_ovf) begin
            special_res = '0;
        end else begin
            special = 1'b0;
        end
    end

    // ---------------- FSM ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = result_q;

    // ---------------- shared adder ----------------
    logic            op_is_mul_q;
    logic [XLEN:0]   add_a, add_b, add_sum;
    logic            add_sub, add_cout;

    assign op_is_mul_q = |op_q[OP_MULHSU:OP_MUL];

    always_comb begin
        add_a   = {1'b0, acc_q};
        add_b   = '0;
        add_sub = 1'b0;
        if (op_is_mul_q) begin
            // Add the multiplicand only when the current multiplier bit is set.
            add_b = lsr_q[0] ? {1'b0, opnd_q} : '0;
        end else begin
            // Trial subtract from the remainder shifted left by one dividend bit.
            add_a   = {acc_q, lsr_q[XLEN-1]};
            add_b   = {1'b0, opnd_q};
            add_sub = 1'b1;
        end
    end

    mdu_addsub #(.W(XLEN + 1)) u_addsub (
        .a    (add_a),
        .b    (add_b),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // ---------------- datapath ----------------
    // NOTE: datapath registers are reset too, so no stale operand or partial
    // result survives a reset taken mid-operation.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            lsr_q   <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            op_q    <= op;
            sign1_q <= neg1;
            sign2_q <= neg2;
            opnd_q  <= is_mul ? abs1 : abs2;
            lsr_q   <= is_mul ? abs2 : abs1;
            acc_q   <= '0;
            cnt_q   <= CNT_W'(XLEN);
        end else if (state == CALC) begin
            cnt_q <= cnt_q - 1'b1;
            if (op_is_mul_q) begin
                acc_q <= add_sum[XLEN:1];
                lsr_q <= {add_sum[0], lsr_q[XLEN-1:1]};
            end else begin
                acc_q <= add_cout ? add_sum[XLEN-1:0] : add_a[XLEN-1:0];
                lsr_q <= {lsr_q[XLEN-2:0], add_cout};
            end
        end
    end

    // ---------------- sign fix and result select ----------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

    always_comb begin
        prod_fix = {acc_q, lsr_q};
        if (sign1_q ^ sign2_q) prod_fix = ~prod_fix + 1'b1;
        quo_fix = (sign1_q ^ sign2_q) ? (~lsr_q + 1'b1) : lsr_q;
        rem_fix = sign1_q ? (~acc_q + 1'b1) : acc_q;

        fix_res = rem_fix;
        if (op_q[OP_MUL])
            fix_res = prod_fix[XLEN-1:0];
        else if (op_q[OP_MULH] | op_q[OP_MULHU] | op_q[OP_MULHSU])
            fix_res = prod_fix[2*XLEN-1:XLEN];
        else if (op_q[OP_DIV] | op_q[OP_DIVU])
            fix_res = quo_fix;
    end

    // The result register only moves on entry to DONE, so it holds through backpressure.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
        end else if (accept && special) begin
            result_q <= special_res;
        end else if ((state == FIX) && !flush) begin
            result_q <= fix_res;
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed table, hand-written corner sequences
// (backpressure, flush, reset mid-operation) and random ops against an
// arithmetic reference model.
module tb_mdu_seq;
    import mdu_pkg::*;

    logic clock;
    logic reset_n;
    logic flush;

    mdu_seq_if bus ();

    mdu_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_onehot(input logic [7:0] op);
        return (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] sa, sb, za, zb, p;
        longint       ia, ib;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        za = {64'd0, a};
        zb = {64'd0, b};
        ia = a;
        ib = b;
        if (!is_onehot(op)) return 64'd0;
        case (1'b1)
            op[0]: begin p = sa * sb; return p[63:0];   end
            op[1]: begin p = sa * sb; return p[127:64]; end
            op[2]: begin p = za * zb; return p[127:64]; end
            op[3]: begin p = sa * zb; return p[127:64]; end
            op[4]: begin
                if (b == 64'd0) return '1;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return a;
                return 64'(ia / ib);
            end
            op[5]: return (b == 64'd0) ? '1 : a / b;
            op[6]: begin
                if (b == 64'd0) return a;
                if (a == 64'h8000_0000_0000_0000 && b == '1) return 64'd0;
                return 64'(ia % ib);
            end
            default: return (b == 64'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [7:0] op, input logic [63:0] a,
                                       input logic [63:0] b);
        bit ovf;
        ovf = (a == 64'h8000_0000_0000_0000) && (b == '1);
        if (!is_onehot(op)) return 1;
        if ((op[4] | op[5] | op[6] | op[7]) && b == 64'd0) return 1;
        if ((op[4] | op[6]) && ovf) return 1;
        return 66;
    endfunction

    // ---------------- transaction driver ----------------
    // Drives one request, waits for the result, holds out_ready low for
    // 'hold' cycles, then completes the handshake. lat counts clock edges from
    // the accept edge (inclusive) to the edge where out_valid rose.
    task automatic run_op(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                          input int hold, output logic [63:0] res, output int lat);
        int guard;
        @(negedge clock);
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        repeat (hold) @(negedge clock);
        res = bus.out_result;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam logic [7:0] MUL = 8'h01, MULH = 8'h02, MULHU = 8'h04, MULHSU = 8'h08;
    localparam logic [7:0] DIV = 8'h10, DIVU = 8'h20, REM = 8'h40, REMU = 8'h80;
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] IMIN = 64'h8000_0000_0000_0000;

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 9))
            0:       return 64'd0;
            1:       return M1;
            2:       return IMIN;
            3:       return 64'(unsigned'($urandom_range(1, 20)));
            4:       return -64'(unsigned'($urandom_range(1, 20)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [16];
        logic [63:0] res, held;
        int          lat, ov_seen;

        tbl[0]  = '{"mul -3*7",        MUL,    -64'sd3, 64'd7,   64'hFFFF_FFFF_FFFF_FFEB, 66};
        tbl[1]  = '{"mulh -1*-1",      MULH,   M1,      M1,      64'd0,                   66};
        tbl[2]  = '{"mulhu -1*-1",     MULHU,  M1,      M1,      64'hFFFF_FFFF_FFFF_FFFE, 66};
        tbl[3]  = '{"mulhsu -1*-1",    MULHSU, M1,      M1,      M1,                      66};
        tbl[4]  = '{"div -7/2",        DIV,    -64'sd7, 64'd2,   -64'sd3,                 66};
        tbl[5]  = '{"rem -7/2",        REM,    -64'sd7, 64'd2,   M1,                      66};
        tbl[6]  = '{"divu 100/7",      DIVU,   64'd100, 64'd7,   64'd14,                  66};
        tbl[7]  = '{"remu 100/7",      REMU,   64'd100, 64'd7,   64'd2,                   66};
        tbl[8]  = '{"div 5/0",         DIV,    64'd5,   64'd0,   M1,                      1};
        tbl[9]  = '{"rem 5/0",         REM,    64'd5,   64'd0,   64'd5,                   1};
        tbl[10] = '{"div intmin/-1",   DIV,    IMIN,    M1,      IMIN,                    1};
        tbl[11] = '{"rem intmin/-1",   REM,    IMIN,    M1,      64'd0,                   1};
        tbl[12] = '{"divu 9/0",        DIVU,   64'd9,   64'd0,   M1,                      1};
        tbl[13] = '{"remu 9/0",        REMU,   64'd9,   64'd0,   64'd9,                   1};
        tbl[14] = '{"op zero",         8'h00,  64'd3,   64'd4,   64'd0,                   1};
        tbl[15] = '{"op multihot",     8'h11,  64'd3,   64'd4,   64'd0,                   1};

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("reset in_ready",   64'(bus.in_ready),  64'd1);
        check("reset busy",       64'(bus.busy),      64'd0);
        check("reset out_valid",  64'(bus.out_valid), 64'd0);
        check("reset out_result", bus.out_result,     64'd0);
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, 0, res, lat);
            check({tbl[i].name, " result"},  res,     tbl[i].exp);
            check({tbl[i].name, " latency"}, 64'(lat), 64'(tbl[i].lat));
        end

        // Backpressure: result and in_ready stay put while out_ready is low.
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_op = MUL; bus.in_src1 = 64'd123456789; bus.in_src2 = 64'd1000;
        @(negedge clock);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        check("bp latency", 64'(lat), 64'd66);
        held = bus.out_result;
        check("bp result", held, 64'd123456789000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("bp result stable", bus.out_result, held);
            check("bp in_ready low",  64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.out_ready = 1'b0;
        check("bp release out_valid", 64'(bus.out_valid), 64'd0);
        check("bp release in_ready",  64'(bus.in_ready),  64'd1);

        // Flush in the middle of CALC: back to IDLE, no output ever appears.
        @(negedge clock);
        bus.in_valid = 1'b1; bus.in_op = DIVU; bus.in_src1 = 64'd999; bus.in_src2 = 64'd3;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (29) @(negedge clock);
        check("flush pre busy", 64'(bus.busy), 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush busy",     64'(bus.busy),     64'd0);
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
        ov_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            if (bus.out_valid) ov_seen++;
        end
        check("flush no out_valid", 64'(ov_seen), 64'd0);
        check("flush result kept",  bus.out_result, held);

        // Flush coinciding with a request in IDLE: nothing is accepted.
        bus.in_valid = 1'b1; bus.in_op = DIV; bus.in_src1 = 64'd5; bus.in_src2 = 64'd0;
        flush = 1'b1;
        @(negedge clock);
        bus.in_valid = 1'b0;
        flush = 1'b0;
        check("flush+accept busy",      64'(bus.busy),      64'd0);
        check("flush+accept out_valid", 64'(bus.out_valid), 64'd0);
        check("flush+accept result",    bus.out_result,     held);

        // Reset mid-CALC: outputs return to reset values at once.
        bus.in_valid = 1'b1; bus.in_op = MULH; bus.in_src1 = M1; bus.in_src2 = 64'd77;
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("rst mid in_ready",   64'(bus.in_ready),  64'd1);
        check("rst mid busy",       64'(bus.busy),      64'd0);
        check("rst mid out_valid",  64'(bus.out_valid), 64'd0);
        check("rst mid out_result", bus.out_result,     64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        ov_seen = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clock);
            if (bus.out_valid) ov_seen++;
        end
        check("rst mid no out_valid", 64'(ov_seen), 64'd0);

        // Random ops with random backpressure against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  op;
            logic [63:0] a, b;
            if ($urandom_range(0, 19) == 0) op = 8'($urandom);
            else                            op = 8'(1 << $urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            run_op(op, a, b, $urandom_range(0, 3), res, lat);
            check($sformatf("rand op=%h a=%h b=%h result", op, a, b), res, ref_result(op, a, b));
            check($sformatf("rand op=%h latency", op), 64'(lat), 64'(ref_latency(op, a, b)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
